// File: rtl/cpu_pack_pkg.sv
// Shared widths, FSM state type and tkeep helper for the CPU-to-AXIS frame packer.
package cpu_pack_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned KEEP_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } pack_state_e;

    // Low-order byte mask of n bytes; n=16 yields a full mask.
    function automatic logic [KEEP_W-1:0] keep_from_bytes(input logic [4:0] n);
        logic [KEEP_W:0] m;
        m = ({{KEEP_W{1'b0}}, 1'b1} << n) - {{KEEP_W{1'b0}}, 1'b1};
        return m[KEEP_W-1:0];
    endfunction

endpackage

// File: rtl/cpu_axis_packer.sv
// Packs CPU-written 32-bit words into 128-bit AXIS beats with tkeep/tlast from the header length.
// Optional CPU_PACK_STATS_EN adds frame and error counters.
module cpu_axis_packer
    import cpu_pack_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned USER_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctl_we,
    input  logic [LEN_W-1:0]    ctl_len,
    input  logic [USER_W-1:0]   ctl_user,
    input  logic                dat_we,
    input  logic [WORD_W-1:0]   dat_wdata,
    output logic                wr_rdy,
    output logic                busy,
    output logic                err,
    input  logic                err_clr,
`ifdef CPU_PACK_STATS_EN
    output logic [31:0]         stat_frames,
    output logic [15:0]         stat_errs,
`endif
    output logic [DATA_W-1:0]   m_tdata,
    output logic [KEEP_W-1:0]   m_tkeep,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [USER_W-1:0]   m_tuser
);

    pack_state_e         state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [1:0]          widx_q, widx_d;
    logic [4:0]          bytes_q, bytes_d;
    logic [USER_W-1:0]   user_q, user_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [KEEP_W-1:0]   keep_q, keep_d;
    logic                last_q, last_d;
    logic                tvalid_q, tvalid_d;
    logic                wr_rdy_q, wr_rdy_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                err_ev;
    logic [2:0]          take;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        widx_d   = widx_q;
        bytes_d  = bytes_q;
        user_d   = user_q;
        data_d   = data_q;
        keep_d   = keep_q;
        last_d   = last_q;
        take     = (rem_q >= LEN_W'(4)) ? 3'd4 : rem_q[2:0];

        err_ev = (ctl_we && (busy_q || (ctl_len == '0))) || (dat_we && !wr_rdy_q);

        unique case (state_q)
            IDLE: begin
                if (ctl_we && (ctl_len != '0)) begin
                    state_d = FILL;
                    rem_d   = ctl_len;
                    user_d  = ctl_user;
                    widx_d  = '0;
                    bytes_d = '0;
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                end
            end
            FILL: begin
                if (dat_we) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (widx_q == 2'(k)) begin
                            data_d[k*WORD_W +: WORD_W] = dat_wdata;
                        end
                    end
                    rem_d   = rem_q - LEN_W'(take);
                    bytes_d = bytes_q + {2'b00, take};
                    widx_d  = widx_q + 2'd1;
                    // Beat closes on the fourth lane or on the final byte of the frame.
                    if ((widx_q == 2'd3) || (rem_d == '0)) begin
                        state_d = SEND;
                        keep_d  = keep_from_bytes(bytes_d);
                        last_d  = (rem_d == '0);
                    end
                end
            end
            SEND: begin
                if (m_tready) begin
                    keep_d = '0;
                    last_d = 1'b0;
                    if (rem_q != '0) begin
                        state_d = FILL;
                        widx_d  = '0;
                        bytes_d = '0;
                        data_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d = (state_d == SEND);
        wr_rdy_d = (state_d == FILL);
        busy_d   = (state_d != IDLE);
        err_d    = err_ev | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            widx_q   <= '0;
            bytes_q  <= '0;
            user_q   <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            tvalid_q <= 1'b0;
            wr_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            widx_q   <= widx_d;
            bytes_q  <= bytes_d;
            user_q   <= user_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            tvalid_q <= tvalid_d;
            wr_rdy_q <= wr_rdy_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign wr_rdy   = wr_rdy_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign m_tdata  = data_q;
    assign m_tkeep  = keep_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = last_q;
    assign m_tuser  = user_q;

`ifdef CPU_PACK_STATS_EN
    logic [31:0] stat_frames_q, stat_frames_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_errs_d   = stat_errs_q;
        if (tvalid_q && m_tready && last_q) begin
            stat_frames_d = stat_frames_q + 32'd1;
        end
        if (err_ev && (stat_errs_q != '1)) begin
            stat_errs_d = stat_errs_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_frames_q <= '0;
            stat_errs_q   <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule
